// File: rtl/word2text.sv
// Binary-word to ASCII hex printer: emits NIBBLES hex digits MSB first over a
// valid/ready stream, optionally followed by a line-feed terminator.
module word2text #(
  parameter int NIBBLES = 4,
  parameter bit UPPER   = 1'b1,
  parameter bit TERM    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_char,
  output logic                 out_last,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    TERMC = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic [3:0]     next_nib;

  // Nibble that becomes visible once the current digit has been taken.
  generate
    if (NIBBLES > 1) begin : g_multi
      assign next_nib = shreg[W-5 -: 4];
    end else begin : g_single
      assign next_nib = 4'h0;
    end
  endgenerate

  function automatic logic [7:0] enc(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return (UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'h0a;
  endfunction

  // All outputs are registered so out_char/out_last never see in_data directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= DIGIT;
            shreg     <= in_data;
            cnt       <= CW'(NIBBLES - 1);
            out_valid <= 1'b1;
            out_char  <= enc(in_data[W-1 -: 4]);
            out_last  <= (TERM == 1'b0) && (NIBBLES == 1);
            busy      <= 1'b1;
            in_ready  <= 1'b0;
          end
        end

        DIGIT: begin
          if (out_ready) begin
            shreg <= shreg << 4;
            if (cnt == '0) begin
              if (TERM) begin
                state    <= TERMC;
                out_char <= 8'h0a;
                out_last <= 1'b1;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_char  <= 8'h00;
                out_last  <= 1'b0;
                busy      <= 1'b0;
                in_ready  <= 1'b1;
              end
            end else begin
              cnt      <= cnt - CW'(1);
              out_char <= enc(next_nib);
              out_last <= (TERM == 1'b0) && (cnt == CW'(1));
            end
          end
        end

        TERMC: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_char  <= 8'h00;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word2text.sv
// Bench for word2text: two instances (upper+LF, lower without LF) checked every
// cycle against a character-queue model, plus literal transcript checks.
module tb_word2text;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        ir_a, ov_a, ol_a, bz_a;
  logic [7:0]  oc_a;
  logic        ir_b, ov_b, ol_b, bz_b;
  logic [7:0]  oc_b;

  int vec = 0;
  int mis = 0;

  string m [2];
  string log_a = "";
  string log_b = "";

  always #5 clk = ~clk;

  word2text #(.NIBBLES(4), .UPPER(1'b1), .TERM(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_char(oc_a), .out_last(ol_a), .busy(bz_a)
  );

  word2text #(.NIBBLES(4), .UPPER(1'b0), .TERM(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_char(oc_b), .out_last(ol_b), .busy(bz_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // Expected character stream for one word.
  function automatic string build(input logic [15:0] d, input bit up, input bit term);
    string digs;
    string s;
    int    idx;
    digs = up ? "0123456789ABCDEF" : "0123456789abcdef";
    s = "";
    for (int i = 3; i >= 0; i--) begin
      idx = int'((d >> (4 * i)) & 16'h000f);
      s = {s, $sformatf("%c", digs[idx])};
    end
    if (term) s = {s, "\n"};
    return s;
  endfunction

  // Model: a word is a queue of pending characters; empty queue means idle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] = "";
      m[1] = "";
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m[k].len() == 0) begin
          if (in_valid) m[k] = build(in_data, (k == 0), (k == 0));
        end else if (out_ready) begin
          m[k] = m[k].substr(1, m[k].len() - 1);
        end
      end
    end
  end

  // Transcript of characters actually transferred.
  always @(posedge clk) begin
    if (rst_n && out_ready) begin
      if (ov_a) log_a = {log_a, $sformatf("%c", oc_a)};
      if (ov_b) log_b = {log_b, $sformatf("%c", oc_b)};
    end
  end

  task automatic cmp(input int k, input logic v, input logic [7:0] c, input logic l,
                     input logic b, input logic r);
    string s;
    logic  e;
    s = m[k];
    e = (s.len() > 0);
    chk($sformatf("dut%0d out_valid", k), 32'(v), 32'(e));
    chk($sformatf("dut%0d out_char", k), 32'(c), e ? 32'(s[0]) : 32'h0);
    chk($sformatf("dut%0d out_last", k), 32'(l), 32'(s.len() == 1));
    chk($sformatf("dut%0d busy", k), 32'(b), 32'(e));
    chk($sformatf("dut%0d in_ready", k), 32'(r), 32'(!e));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      cmp(0, ov_a, oc_a, ol_a, bz_a, ir_a);
      cmp(1, ov_b, oc_b, ol_b, bz_b, ir_b);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log_a = "";
    log_b = "";
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " a out_valid"}, 32'(ov_a), 32'h0);
    chk({tag, " a out_char"},  32'(oc_a), 32'h0);
    chk({tag, " a out_last"},  32'(ol_a), 32'h0);
    chk({tag, " a busy"},      32'(bz_a), 32'h0);
    chk({tag, " a in_ready"},  32'(ir_a), 32'h1);
    chk({tag, " b out_valid"}, 32'(ov_b), 32'h0);
    chk({tag, " b in_ready"},  32'(ir_b), 32'h1);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    step(2);

    // Pin the model itself with hand-written strings.
    chks("model 1A2F", build(16'h1A2F, 1'b1, 1'b1), "1A2F\n");
    chks("model beef", build(16'hBEEF, 1'b0, 1'b0), "beef");

    // Release reset and offer a word in the same cycle: accepted on first edge.
    rst_n = 1'b1;
    clear_logs();
    send(16'h1A2F);
    step(8);
    chks("1A2F stream a", log_a, "1A2F\n");
    chks("1A2F stream b", log_b, "1a2f");

    clear_logs();
    send(16'hBEEF);
    step(8);
    chks("BEEF stream a", log_a, "BEEF\n");
    chks("BEEF stream b", log_b, "beef");

    // Stalling sink; in_valid pulses while both instances are busy.
    clear_logs();
    out_ready = 1'b0;
    send(16'h09F0);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2) == 1;
      in_valid  = (i == 1) || (i == 3);
      in_data   = in_valid ? 16'hDEAD : 16'h09F0;
      step(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(4);
    chks("09F0 stall a", log_a, "09F0\n");
    chks("09F0 stall b", log_b, "09f0");

    // Back-to-back words with in_valid held high.
    clear_logs();
    in_valid = 1'b1;
    in_data  = 16'h0000;
    step(1);
    in_data = 16'hFFFF;
    step(6);
    in_valid = 1'b0;
    step(8);
    chks("b2b stream a", log_a, "0000\nFFFF\n");
    chks("b2b stream b", log_b, "0000ffff");

    // Asynchronous reset mid-word.
    clear_logs();
    send(16'h1234);
    step(2);
    chks("pre-reset a", log_a, "12");
    rst_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    step(1);
    rst_n = 1'b1;
    clear_logs();
    step(4);
    chks("post-reset silence a", log_a, "");
    chks("post-reset silence b", log_b, "");
    send(16'h5678);
    step(8);
    chks("5678 stream a", log_a, "5678\n");
    chks("5678 stream b", log_b, "5678");

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/word2text.md
WORD2TEXT -- requirements
Module: word2text

Interface
REQ-001 SHALL have the following parameters:
- NIBBLES, 4: number of hex digits emitted per word (1..8).
- UPPER, 1: 1 = digits A-F encode as 0x41-0x46; 0 = they encode as 0x61-0x66.
- TERM, 1: 1 = append line-feed 0x0A after the last digit; 0 = no terminator.

REQ-002 SHALL have the following ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word.
- in_data  input  4*NIBBLES  binary word to print.
- out_valid  output  1  out_char holds a valid character.
- out_ready  input  1  sink accepts the character.
- out_char  output  8  ASCII character.
- out_last  output  1  current character is the final one of the word.
- busy  output  1  a word is being emitted.

Function
REQ-003 SHALL implement FSM states IDLE, DIGIT, TERMC.
REQ-004 In IDLE, in_ready SHALL be 1; every other output SHALL be 0.
REQ-005 A word SHALL be accepted on a rising edge with in_valid=1 and in_ready=1. The FSM SHALL go to DIGIT, latch in_data into an internal shift register, and set digit counter = NIBBLES-1.
REQ-006 out_valid SHALL assert in the cycle after acceptance (latency 1). No character SHALL be presented in the accept cycle.
REQ-007 Digits SHALL be emitted MSB nibble first. Nibble n SHALL encode as 0x30+n for n=0..9, and as 0x41+(n-10) (UPPER=1) or 0x61+(n-10) (UPPER=0) for n=10..15.
REQ-008 A character SHALL transfer only on a rising edge with out_valid=1 and out_ready=1. On transfer, the shift register SHALL shift left 4 and the counter SHALL decrement.
REQ-009 While out_valid=1 and out_ready=0, out_char, out_last and internal state SHALL hold unchanged (no drop, no duplicate).
REQ-010 On transfer of the last digit (counter=0):
- TERM=1: the FSM SHALL go to TERMC.
- TERM=0: the FSM SHALL go to IDLE.
REQ-011 In TERMC, out_char SHALL be 0x0A with out_valid=1. On transfer the FSM SHALL go to IDLE.
REQ-012 out_last SHALL be 1 only on the final character of the word: 0x0A when TERM=1, otherwise the least significant digit.
REQ-013 in_ready SHALL be 0 in DIGIT and TERMC. Inputs presented then SHALL be ignored and not queued.
REQ-014 After the final transfer, in_ready SHALL return to 1 in the next cycle. Minimum word period SHALL be NIBBLES+TERM+1 cycles.
REQ-015 busy SHALL equal (state != IDLE).
REQ-016 out_valid SHALL be registered. out_char and out_last SHALL derive only from registered state, with no combinational path from in_data or in_valid.
REQ-017 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-018 Counter width SHALL be ceil(log2(NIBBLES)), minimum 1 bit, and SHALL NOT wrap below 0 within a word.

Reset
REQ-019 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, shift register=0, counter=0, out_valid=0, out_char=0x00, out_last=0, busy=0, in_ready=1.
REQ-020 Reset asserted mid-word SHALL discard the word. After release, no remaining characters SHALL be emitted.
REQ-021 The first acceptance after reset release SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-022 Default parameters, in_data=16'h1A2F, out_ready=1 always -> out_char sequence 0x31,0x41,0x32,0x46,0x0A on 5 consecutive cycles starting 1 cycle after accept; out_last=1 only with 0x0A; in_ready=1 the following cycle.
REQ-023 UPPER=0, TERM=0, in_data=16'hBEEF -> 0x62,0x65,0x65,0x66; out_last with the final 0x66; no 0x0A emitted.
REQ-024 in_data=16'h09F0, out_ready toggled 0/1 every cycle -> out_char held stable while stalled; exactly 0x30,0x39,0x46,0x30,0x0A delivered; in_valid pulses during busy ignored.
REQ-025 in_data=16'h0000, then 16'hFFFF back-to-back with in_valid held high -> "0000\n" then "FFFF\n"; in_ready low throughout each word; second accept on the cycle after the first 0x0A transfer.
REQ-026 in_data=16'h1234, rst_n pulsed low asynchronously after 0x31,0x32 transferred -> outputs clear before the next clk edge; after release no 0x33/0x34 appear; new word 16'h5678 yields "5678\n".
